pll_lock_mgr: RTL and testbench

PLL_LOCK_MGR -- requirements
Module: pll_lock_mgr

---
 rtl/pll_lock_mgr_if.sv | 12 +
 rtl/pll_lock_mgr.sv | 74 +++++++
 tb/tb_pll_lock_mgr.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pll_lock_mgr_if.sv
// pll_lock_mgr_if: lock status in, reset/ready/status out for the PLL lock manager.
interface pll_lock_mgr_if;
    logic       lock_in;
    logic       pll_reset;
    logic       rst_out;
    logic       pll_ready;
    logic [7:0] lol_cnt;
    logic       tmo_flag;
    logic [2:0] state_o;
    modport slave (input lock_in, output pll_reset, rst_out, pll_ready, lol_cnt, tmo_flag, state_o);
    modport master (output lock_in, input pll_reset, rst_out, pll_ready, lol_cnt, tmo_flag, state_o);
endinterface

// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr: sequences PLL reset, qualifies lock and gates downstream reset; LOCK_RETRY_EN makes a lock timeout retry the PLL reset.
module pll_lock_mgr #(
    parameter int RST_CYC  = 16,
    parameter int FILT_CYC = 1024,
    parameter int REL_CYC  = 64,
    parameter int TMO_CYC  = 1000000
) (
    input logic            clkin,
    input logic            reset,
    pll_lock_mgr_if.slave  bus
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;
    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [23:0] cnt_q;
    logic        pll_reset_q, rst_out_q, tmo_q, tmo_hit, lock_s;
    logic [7:0]  lol_q;
    assign lock_s        = sync_q[1];
    assign bus.pll_reset = pll_reset_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.pll_ready = ~rst_out_q;
    assign bus.lol_cnt   = lol_q;
    assign bus.tmo_flag  = tmo_q;
    assign bus.state_o   = state_q;
    // Next-state decode; lock is accepted one edge after FILT_CYC qualified samples, any low sample restarts it.
    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            PLL_RST:   state_d = (cnt_q == 24'(RST_CYC - 1)) ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                if (lock_s) state_d = FILTER;
                else if (cnt_q == 24'(TMO_CYC - 1)) begin
                    tmo_hit = 1'b1;
`ifdef LOCK_RETRY_EN
                    state_d = PLL_RST;
`else
                    state_d = WAIT_LOCK;
`endif
                end
            end
            FILTER:    state_d = !lock_s ? WAIT_LOCK : (cnt_q == 24'(FILT_CYC)) ? RELEASE : FILTER;
            RELEASE:   state_d = !lock_s ? WAIT_LOCK : (cnt_q == 24'(REL_CYC - 1)) ? RUN : RELEASE;
            RUN:       state_d = !lock_s ? PLL_RST : RUN;
            default:   state_d = PLL_RST;
        endcase
    end
    // State, per-state counter, synchronizer and outputs registered from the next state so they change on the transition edge.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b00;
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            tmo_q       <= 1'b0;
            lol_q       <= 8'd0;
        end else begin
            sync_q      <= {sync_q[0], bus.lock_in};
            state_q     <= state_d;
            cnt_q       <= (state_d != state_q || tmo_hit) ? '0 : cnt_q + 24'd1;
            pll_reset_q <= state_d == PLL_RST;
            rst_out_q   <= state_d != RUN;
            if (tmo_hit) tmo_q <= 1'b1;
            if (state_q == RUN && !lock_s && lol_q != 8'hff) lol_q <= lol_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_pll_lock_mgr.sv
// tb_pll_lock_mgr: directed checks of lock sequencing, glitch restart, loss-of-lock, timeout and async reset.
module tb_pll_lock_mgr;
    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    pll_lock_mgr_if bus ();
    pll_lock_mgr #(.RST_CYC(4), .FILT_CYC(8), .REL_CYC(4), .TMO_CYC(32)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clkin = ~clkin;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask
    task automatic do_reset(input logic l);
        bus.lock_in = l;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.state_o), 0);
        chk({tag, "_pll_reset"}, 32'(bus.pll_reset), 1);
        chk({tag, "_rst_out"}, 32'(bus.rst_out), 1);
        chk({tag, "_ready"}, 32'(bus.pll_ready), 0);
        chk({tag, "_lol"}, 32'(bus.lol_cnt), 0);
        chk({tag, "_tmo"}, 32'(bus.tmo_flag), 0);
    endtask
    initial begin
        bus.lock_in = 1'b1;
        tick(2);
        chk_reset_vals("por");
        do_reset(1'b1);
        tick(3);
        chk("clean_pllrst_e3", 32'(bus.pll_reset), 1);
        tick(1);
        chk("clean_pllrst_e4", 32'(bus.pll_reset), 0);
        chk("clean_state_e4", 32'(bus.state_o), 1);
        tick(13);
        chk("clean_rst_e17", 32'(bus.rst_out), 1);
        chk("clean_rdy_e17", 32'(bus.pll_ready), 0);
        tick(1);
        chk("clean_rst_e18", 32'(bus.rst_out), 0);
        chk("clean_rdy_e18", 32'(bus.pll_ready), 1);
        chk("clean_state_e18", 32'(bus.state_o), 4);
        do_reset(1'b1);
        tick(5);
        chk("gl_state_e5", 32'(bus.state_o), 2);
        tick(2);
        bus.lock_in = 1'b0;
        tick(1);
        bus.lock_in = 1'b1;
        tick(2);
        chk("gl_state_e10", 32'(bus.state_o), 1);
        tick(1);
        chk("gl_state_e11", 32'(bus.state_o), 2);
        tick(12);
        chk("gl_rst_e23", 32'(bus.rst_out), 1);
        tick(1);
        chk("gl_rst_e24", 32'(bus.rst_out), 0);
        chk("gl_rdy_e24", 32'(bus.pll_ready), 1);
        chk("gl_state_e24", 32'(bus.state_o), 4);
        bus.lock_in = 1'b0;
        tick(2);
        chk("lol_rst_j2", 32'(bus.rst_out), 0);
        tick(1);
        chk("lol_rst_j3", 32'(bus.rst_out), 1);
        chk("lol_state_j3", 32'(bus.state_o), 0);
        chk("lol_cnt1", 32'(bus.lol_cnt), 1);
        chk("lol_pllrst_j3", 32'(bus.pll_reset), 1);
        bus.lock_in = 1'b1;
        tick(3);
        chk("lol_pllrst_j6", 32'(bus.pll_reset), 1);
        tick(1);
        chk("lol_pllrst_j7", 32'(bus.pll_reset), 0);
        tick(13);
        chk("lol_state_j20", 32'(bus.state_o), 3);
        tick(1);
        chk("lol_state_j21", 32'(bus.state_o), 4);
        for (int i = 2; i <= 300; i++) begin
            bus.lock_in = 1'b0;
            tick(3);
            bus.lock_in = 1'b1;
            tick(18);
            if (i == 128) chk("lol_cnt128", 32'(bus.lol_cnt), 128);
            if (i == 300) chk("lol_relock_last", 32'(bus.state_o), 4);
        end
        chk("lol_sat", 32'(bus.lol_cnt), 255);
        reset = 1'b1;
        #1;
        chk_reset_vals("arst_run");
        do_reset(1'b0);
        tick(35);
        chk("tmo_e35", 32'(bus.tmo_flag), 0);
        chk("tmo_state_e35", 32'(bus.state_o), 1);
        tick(1);
        chk("tmo_e36", 32'(bus.tmo_flag), 1);
`ifdef LOCK_RETRY_EN
        chk("tmo_state_e36", 32'(bus.state_o), 0);
        chk("tmo_pllrst_e36", 32'(bus.pll_reset), 1);
        tick(35);
        chk("tmo_state_e71", 32'(bus.state_o), 1);
        tick(1);
        chk("tmo_state_e72", 32'(bus.state_o), 0);
`else
        chk("tmo_state_e36", 32'(bus.state_o), 1);
        chk("tmo_pllrst_e36", 32'(bus.pll_reset), 0);
        tick(36);
        chk("tmo_state_e72", 32'(bus.state_o), 1);
`endif
        chk("tmo_sticky", 32'(bus.tmo_flag), 1);
        reset = 1'b1;
        #1;
        chk("tmo_cleared", 32'(bus.tmo_flag), 0);
        do_reset(1'b1);
        tick(14);
        chk("rel_state_e14", 32'(bus.state_o), 3);
        reset = 1'b1;
        #1;
        chk_reset_vals("arst_rel");
        tick(1);
        reset = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
